// File: rtl/acondicionador_botones.sv
// Four-button conditioner: 2-FF sync, counter debounce, rising-edge one-shot, last-press code.
// Optional auto-repeat of held buttons when BOTONES_AUTOREPEAT_EN is defined.
module acondicionador_botones #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 2000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       botonU_pi,
  input  logic       botonD_pi,
  input  logic       botonL_pi,
  input  logic       botonR_pi,
  output logic       pulso_o,
  output logic [1:0] codigo_o,
  output logic [3:0] estado_o,
  output logic [3:0] pulsos_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]      raw;
  logic [3:0]      s1_q, s2_q;
  logic [3:0]      estado_q, estado_d;
  logic [3:0]      pulsos_q, pulsos_d;
  logic [3:0]      rep_pulse;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];
  logic            pulso_q, pulso_d;
  logic [1:0]      codigo_q, codigo_d;

  assign raw = {botonR_pi, botonL_pi, botonD_pi, botonU_pi};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]    = '0;
      estado_d[i] = estado_q[i];
      if (s2_q[i] != estado_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          estado_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef BOTONES_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(REPEAT_DELAY);
  localparam logic [HoldW-1:0] HoldFire   = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] HoldReload = HoldW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HoldW-1:0] hold_q [4];
  logic [HoldW-1:0] hold_d [4];

  // Reloading to DELAY-PERIOD after each repeat makes the next fire PERIOD cycles later.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hold_d[i]    = '0;
      rep_pulse[i] = 1'b0;
      if (estado_q[i] && estado_d[i]) begin
        if (hold_q[i] == HoldFire) begin
          rep_pulse[i] = 1'b1;
          hold_d[i]    = HoldReload;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (reset_i) begin
        hold_q[i] <= '0;
      end else begin
        hold_q[i] <= hold_d[i];
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_pulse  = 4'b0000;
`endif

  always_comb begin
    pulsos_d = (estado_d & ~estado_q) | rep_pulse;
    pulso_d  = |pulsos_d;
    codigo_d = codigo_q;
    if (pulsos_d[0]) begin
      codigo_d = 2'd0;
    end else if (pulsos_d[1]) begin
      codigo_d = 2'd1;
    end else if (pulsos_d[2]) begin
      codigo_d = 2'd2;
    end else if (pulsos_d[3]) begin
      codigo_d = 2'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      estado_q <= '0;
      pulsos_q <= '0;
      pulso_q  <= 1'b0;
      codigo_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      estado_q <= estado_d;
      pulsos_q <= pulsos_d;
      pulso_q  <= pulso_d;
      codigo_q <= codigo_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pulso_o  = pulso_q;
  assign codigo_o = codigo_q;
  assign estado_o = estado_q;
  assign pulsos_o = pulsos_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: directed test-plan steps plus random bouncing,
// checked every cycle against a sample-window reference model.
module tb_acondicionador_botones;

  localparam int unsigned D  = 8;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic       pulso;
  logic [1:0] codigo;
  logic [3:0] estado, pulsos;

  int checks   = 0;
  int failures = 0;

  // Reference model: bit j of win holds the raw value sampled j edges ago.
  logic [D+1:0] win [4];
  logic [3:0]   est_m, pul_m;
  logic [1:0]   cod_m;
  int           age [4];
  int           cnt_dut, cnt_mod;

  always #5 clk = ~clk;

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .botonU_pi(raw[0]),
    .botonD_pi(raw[1]),
    .botonL_pi(raw[2]),
    .botonR_pi(raw[3]),
    .pulso_o  (pulso),
    .codigo_o (codigo),
    .estado_o (estado),
    .pulsos_o (pulsos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] x);
    logic [3:0] prev;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        win[i] = '0;
        age[i] = 0;
      end
      est_m = '0;
      pul_m = '0;
      cod_m = '0;
      return;
    end
    prev = est_m;
    for (int i = 0; i < 4; i++) begin
      logic [D-1:0] w;
      win[i] = {win[i][D:0], x[i]};
      w = win[i][D+1:2];
      // Flip once the last D synchronized samples all disagree with the accepted level.
      if (prev[i] == 1'b0 && (&w)) est_m[i] = 1'b1;
      if (prev[i] == 1'b1 && !(|w)) est_m[i] = 1'b0;
      pul_m[i] = est_m[i] & ~prev[i];
`ifdef BOTONES_AUTOREPEAT_EN
      if (est_m[i] && prev[i]) begin
        age[i]++;
        if (age[i] >= RD && ((age[i] - RD) % RP) == 0) pul_m[i] = 1'b1;
      end else begin
        age[i] = 0;
      end
`endif
    end
    for (int i = 3; i >= 0; i--) if (pul_m[i]) cod_m = 2'(i);
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge(rst, raw);
      #1;
      chk("estado", 32'(estado), 32'(est_m));
      chk("pulsos", 32'(pulsos), 32'(pul_m));
      chk("pulso", 32'(pulso), 32'(|pul_m));
      chk("codigo", 32'(codigo), 32'(cod_m));
      if (pulsos[0]) cnt_dut++;
      if (pul_m[0]) cnt_mod++;
      if (pulso) cnt_dut += 100;
      if (|pul_m) cnt_mod += 100;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      win[i] = '0;
      age[i] = 0;
    end
    est_m = '0;
    pul_m = '0;
    cod_m = '0;
    cnt_dut = 0;
    cnt_mod = 0;

    // Reset with all buttons held: one combined press after release.
    rst = 1'b1;
    raw = 4'hF;
    step(3);
    #1 rst = 1'b0;
    cnt_dut = 0;
    step(15);
    chk("reset_press_pulse_count", 32'(cnt_dut), 32'(101));

    #1 raw = 4'h0;
    step(15);
    #1 raw[2] = 1'b1;
    step(15);
    chk("L_code", 32'(codigo), 32'(2));
    chk("L_level", 32'(estado[2]), 32'(1));

    // Bouncing D, then held.
    for (int b = 0; b < 4; b++) begin
      #1 raw[1] = (b % 2 == 0);
      step(3);
    end
    #1 raw[1] = 1'b1;
    step(15);
    chk("D_code", 32'(codigo), 32'(1));

    #1 raw[1] = 1'b0;
    step(15);
    #1 raw[3] = 1'b1;
    raw[1] = 1'b1;
    step(15);
    chk("RD_code", 32'(codigo), 32'(1));

    #1 raw[2] = 1'b0;
    step(15);
    chk("L_release_code", 32'(codigo), 32'(1));

    // Long hold on U, then release.
    cnt_dut = 0;
    cnt_mod = 0;
    #1 raw[0] = 1'b1;
    step(70);
    #1 raw[0] = 1'b0;
    step(20);
    chk("U_hold_pulses", 32'(cnt_dut), 32'(cnt_mod));
`ifndef BOTONES_AUTOREPEAT_EN
    chk("U_single_pulse", 32'(cnt_dut), 32'(101));
`endif

    // Random bouncing with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 99) < 6) raw[i] = ~raw[i];
      end
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
